note_sequencer: RTL and testbench
=================================

Name: note_sequencer

Overview:
- Score-driven melody sequencer that sits directly upstream of the tone clock divider.
- Steps through a note score held in ROM, one entry at a time, paced by a beat tick derived from clk.
- For each entry it drives the 11-bit max_preset value the divider needs, plus a tone enable so rests are silent.
- Supports start/stop control, looped playback and a 4-level tempo select.

Parameters:
- BEAT_DIV, 12500000: clk cycles per beat tick at tempo_sel=0; must be ≥ 8.
- SONG_LEN, 64: number of score ROM entries; note_addr width is clog2(SONG_LEN).
- ADDR_W, 6: clog2(SONG_LEN).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  single-cycle pulse; begins playback at address 0
- stop  input  1  single-cycle pulse; aborts playback
- loop_en  input  1  1 = restart at address 0 after end-of-song
- tempo_sel  input  2  beat period = BEAT_DIV >> tempo_sel
- max_preset  output  11  divider terminal count for the current note
- tone_en  output  1  1 while a non-rest note plays
- note_code  output  5  code of the current note
- note_addr  output  ADDR_W  score address of the current note
- busy  output  1  1 in any state except IDLE
- song_done  output  1  one-cycle pulse at song end with no loop

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; beat counter 0.
- Score entry is 9 bits: {dur[3:0], note[4:0]}.
  - note 0 = rest.
  - note 1..21 = three octaves × 7 tones.
  - note 31 = END marker.
  - note 22..30 are treated as rest.
  - dur = duration in beat ticks; dur 0 is treated as 1.
- Score ROM is a synchronous read with 1-cycle latency.
- FSM states: IDLE, FETCH, LOAD, PLAY.
- IDLE: on start (and no stop), clear note_addr and the beat counter, then go to FETCH.
- FETCH: present note_addr to the ROM, then go to LOAD.
- LOAD (ROM data valid):
  - END at addr 0: go to IDLE and pulse song_done. This rule guards the empty song even when loop_en=1.
  - END elsewhere with loop_en=1: note_addr←0, go to FETCH.
  - END elsewhere with loop_en=0: pulse song_done, go to IDLE, clear tone_en.
  - Otherwise: latch note_code and max_preset = NOTE_PRESET[note], set tone_en = (note in 1..21), load remaining = dur (0→1), clear the beat counter, go to PLAY.
- PLAY:
  - The beat counter counts 0..T-1 with T = BEAT_DIV >> tempo_sel; one tick fires at the terminal count.
  - The terminal compare uses ≥, so a tempo change that leaves the counter above the new terminal produces a tick next cycle.
  - On a tick, remaining decrements. When remaining reaches 0, note_addr increments and the FSM goes to FETCH.
  - At address SONG_LEN-1 the increment is treated exactly as reaching END.
- Note-to-note gap: 2 cycles (FETCH+LOAD). max_preset and tone_en hold the previous note's values across the gap, so the downstream divider sees no glitch.
- Latency: start to first max_preset valid = 3 cycles (IDLE→FETCH→LOAD, outputs registered at the end of LOAD).
- stop has priority in every state:
  - next cycle: IDLE, tone_en=0, max_preset=0, note_code=0, busy=0.
  - note_addr is held; song_done is not pulsed.
- start while busy is ignored. start and stop in the same cycle: stop wins.
- Asserting reset mid-song returns every output to its reset value immediately.
- loop_en and tempo_sel are sampled live, with no latching.

Decomposition:
- Shared package music_pkg holds:
  - NOTE_W=5, PRESET_W=11, DUR_W=4.
  - NOTE_REST=0, NOTE_END=31.
  - NOTE_PRESET[0:31] constant table: e.g. code 1→11'd1911, code 8→11'd955, code 15→11'd477, all rest/unused codes→0.
  - FSM state enum.
- One sub-module, score_rom: a parameterised 9-bit × SONG_LEN synchronous ROM with init file, instanced once.

Test Plan:
1. Reset mid-PLAY with BEAT_DIV=8 → all outputs 0 in the same cycle as rst_n low; busy stays 0 after release until start.
2. Score {dur2/code1, dur1/code0, dur3/code8, END}, BEAT_DIV=8, tempo_sel=0, loop_en=0, start at cycle 0:
   - max_preset=1911 with tone_en=1 from cycle 3 for 16 cycles;
   - then tone_en=0 for 8 cycles (rest), with a 2-cycle hold gap between notes;
   - then 955 for 24 cycles;
   - then song_done pulses once and busy=0.
3. Same score with loop_en=1 → after code8, note_addr returns to 0 and 1911 reappears 2 cycles after the END fetch; song_done never pulses.
4. Score starting with END, loop_en=1 → song_done at cycle 3, busy=0, no lockup.
5. tempo_sel changed from 0 to 2 while the counter is at 5 with BEAT_DIV=16 → tick on the next cycle (5 ≥ 3), then every 4 cycles.
6. stop during PLAY, and start+stop in the same cycle while in IDLE → IDLE next cycle with tone_en=0 and max_preset=0; the simultaneous start+stop never sets busy.

Source files
------------

// File: rtl/music_pkg.sv
// Shared definitions for the melody sequencer.
//   - Field widths of a score entry {dur, note}
//   - Special note codes (rest, end-of-song)
//   - NOTE_PRESET: tone divider terminal count per note code
//   - Sequencer FSM state encoding
package music_pkg;

    localparam int NOTE_W   = 5;
    localparam int PRESET_W = 11;
    localparam int DUR_W    = 4;
    localparam int ENTRY_W  = DUR_W + NOTE_W;

    localparam logic [NOTE_W-1:0] NOTE_REST = 5'd0;
    localparam logic [NOTE_W-1:0] NOTE_END  = 5'd31;
    localparam logic [NOTE_W-1:0] NOTE_TOP  = 5'd21;

    // Codes 1..21 are C..B over three octaves; every other code is silent.
    localparam logic [PRESET_W-1:0] NOTE_PRESET [0:31] = '{
        11'd0,
        11'd1911, 11'd1703, 11'd1517, 11'd1432, 11'd1275, 11'd1136, 11'd1012,
        11'd955,  11'd851,  11'd758,  11'd716,  11'd638,  11'd568,  11'd506,
        11'd477,  11'd425,  11'd379,  11'd358,  11'd319,  11'd284,  11'd253,
        11'd0, 11'd0, 11'd0, 11'd0, 11'd0, 11'd0, 11'd0, 11'd0, 11'd0, 11'd0
    };

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_LOAD  = 2'd2,
        ST_PLAY  = 2'd3
    } seq_state_t;

    function automatic logic is_tone(input logic [NOTE_W-1:0] code);
        return (code != NOTE_REST) && (code <= NOTE_TOP);
    endfunction

endpackage

// File: rtl/note_sequencer_if.sv
// Control and note-output bundle of the melody sequencer.
//   master: drives start/stop/loop_en/tempo_sel, observes note outputs
//   slave : the sequencer itself
interface note_sequencer_if #(
    parameter int ADDR_W = 6
);
    import music_pkg::*;

    logic                start;
    logic                stop;
    logic                loop_en;
    logic [1:0]          tempo_sel;
    logic [PRESET_W-1:0] max_preset;
    logic                tone_en;
    logic [NOTE_W-1:0]   note_code;
    logic [ADDR_W-1:0]   note_addr;
    logic                busy;
    logic                song_done;

    modport master (
        output start, stop, loop_en, tempo_sel,
        input  max_preset, tone_en, note_code, note_addr, busy, song_done
    );

    modport slave (
        input  start, stop, loop_en, tempo_sel,
        output max_preset, tone_en, note_code, note_addr, busy, song_done
    );

endinterface

// File: rtl/score_rom.sv
// Synchronous score ROM, one-cycle read latency.
//   clk  : read clock
//   addr : entry address
//   data : entry {dur, note}, valid the cycle after addr is presented
// Contents come from the INIT vector, entry i at INIT[i*WIDTH +: WIDTH].
module score_rom #(
    parameter int                     DEPTH  = 64,
    parameter int                     ADDR_W = 6,
    parameter int                     WIDTH  = 9,
    parameter logic [DEPTH*WIDTH-1:0] INIT   = '1
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    output logic [WIDTH-1:0]  data
);

    always_ff @(posedge clk) begin
        data <= INIT[int'(addr)*WIDTH +: WIDTH];
    end

endmodule

// File: rtl/note_sequencer.sv
// Score-driven melody sequencer feeding the tone clock divider.
//   clk, rst_n : system clock, async active-low reset
//   bus        : start/stop/loop_en/tempo_sel in; max_preset, tone_en,
//                note_code, note_addr, busy, song_done out
//
// state | meaning
// IDLE  | stopped, waiting for start
// FETCH | note_addr presented to the score ROM
// LOAD  | ROM entry valid; latch note or handle END
// PLAY  | counting beat ticks for the current note
module note_sequencer
    import music_pkg::*;
#(
    parameter int                         BEAT_DIV = 12500000,
    parameter int                         SONG_LEN = 64,
    parameter int                         ADDR_W   = 6,
    parameter logic [SONG_LEN*ENTRY_W-1:0] SCORE   = '1
) (
    input  logic clk,
    input  logic rst_n,
    note_sequencer_if.slave bus
);

    localparam int CNT_W = $clog2(BEAT_DIV);

    seq_state_t          state, state_next;
    logic [ENTRY_W-1:0]  rom_data;
    logic [NOTE_W-1:0]   rom_note;
    logic [DUR_W-1:0]    rom_dur;
    logic [CNT_W-1:0]    beat_cnt;
    logic [31:0]         beat_term;
    logic [DUR_W-1:0]    remaining;
    logic [ADDR_W-1:0]   note_addr;
    logic [PRESET_W-1:0] max_preset;
    logic [NOTE_W-1:0]   note_code;
    logic                tone_en;
    logic                song_done;
    logic                is_end, at_last, addr_zero, tick, last_beat;
    logic                do_start, do_load, do_wrap, do_done, do_next, busy;

    score_rom #(
        .DEPTH  (SONG_LEN),
        .ADDR_W (ADDR_W),
        .WIDTH  (ENTRY_W),
        .INIT   (SCORE)
    ) u_rom (
        .clk  (clk),
        .addr (note_addr),
        .data (rom_data)
    );

    assign rom_note  = rom_data[NOTE_W-1:0];
    assign rom_dur   = rom_data[ENTRY_W-1:NOTE_W];
    assign is_end    = (rom_note == NOTE_END);
    assign addr_zero = (note_addr == '0);
    assign at_last   = (note_addr == ADDR_W'(SONG_LEN - 1));

    // >= rather than == so a faster tempo never strands the counter above
    // the new terminal count.
    assign beat_term = (32'(BEAT_DIV) >> bus.tempo_sel) - 32'd1;
    assign tick      = (state == ST_PLAY) && (32'(beat_cnt) >= beat_term);
    assign last_beat = tick && (remaining <= DUR_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (bus.stop) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (bus.start) state_next = ST_FETCH;
                ST_FETCH: state_next = ST_LOAD;
                ST_LOAD: begin
                    if (!is_end)                      state_next = ST_PLAY;
                    else if (addr_zero || !bus.loop_en) state_next = ST_IDLE;
                    else                              state_next = ST_FETCH;
                end
                ST_PLAY: begin
                    if (last_beat)
                        state_next = (at_last && !bus.loop_en) ? ST_IDLE : ST_FETCH;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // The last score slot ending behaves exactly like reading END there.
    always_comb begin
        busy     = (state != ST_IDLE);
        do_start = (state == ST_IDLE) && bus.start && !bus.stop;
        do_load  = (state == ST_LOAD) && !is_end && !bus.stop;
        do_wrap  = !bus.stop && bus.loop_en &&
                   (((state == ST_LOAD) && is_end && !addr_zero) || (last_beat && at_last));
        do_done  = !bus.stop &&
                   (((state == ST_LOAD) && is_end && (addr_zero || !bus.loop_en)) ||
                    (last_beat && at_last && !bus.loop_en));
        do_next  = !bus.stop && last_beat && !at_last;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt   <= '0;
            remaining  <= '0;
            note_addr  <= '0;
            max_preset <= '0;
            note_code  <= '0;
            tone_en    <= 1'b0;
            song_done  <= 1'b0;
        end else begin
            song_done <= do_done;
            if (bus.stop) begin
                max_preset <= '0;
                note_code  <= '0;
                tone_en    <= 1'b0;
            end else if (do_start) begin
                note_addr <= '0;
                beat_cnt  <= '0;
            end else if (do_load) begin
                note_code  <= rom_note;
                max_preset <= NOTE_PRESET[rom_note];
                tone_en    <= is_tone(rom_note);
                remaining  <= (rom_dur == '0) ? DUR_W'(1) : rom_dur;
                beat_cnt   <= '0;
            end else begin
                if (do_wrap) note_addr <= '0;
                if (do_next) note_addr <= note_addr + ADDR_W'(1);
                if (do_done) tone_en   <= 1'b0;
                if (state == ST_PLAY) begin
                    if (tick) begin
                        beat_cnt  <= '0;
                        remaining <= remaining - DUR_W'(1);
                    end else begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                    end
                end
            end
        end
    end

    assign bus.max_preset = max_preset;
    assign bus.tone_en    = tone_en;
    assign bus.note_code  = note_code;
    assign bus.note_addr  = note_addr;
    assign bus.busy       = busy;
    assign bus.song_done  = song_done;

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer: three instances share clk/rst_n.
//   u_a : BEAT_DIV=8,  score {d2/c1, d1/rest, d3/c8, END}
//   u_b : BEAT_DIV=8,  score starting with END
//   u_c : BEAT_DIV=16, same score as u_a (tempo change)
module tb_note_sequencer;
    import music_pkg::*;

    localparam logic [64*9-1:0] SCORE_A =
        {{61{9'h1FF}}, {4'd3, 5'd8}, {4'd1, 5'd0}, {4'd2, 5'd1}};
    localparam logic [64*9-1:0] SCORE_B = {64{9'h1FF}};

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    always #5 clk = ~clk;

    note_sequencer_if #(.ADDR_W(6)) bus_a ();
    note_sequencer_if #(.ADDR_W(6)) bus_b ();
    note_sequencer_if #(.ADDR_W(6)) bus_c ();

    note_sequencer #(.BEAT_DIV(8),  .SONG_LEN(64), .ADDR_W(6), .SCORE(SCORE_A))
        u_a (.clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
    note_sequencer #(.BEAT_DIV(8),  .SONG_LEN(64), .ADDR_W(6), .SCORE(SCORE_B))
        u_b (.clk(clk), .rst_n(rst_n), .bus(bus_b.slave));
    note_sequencer #(.BEAT_DIV(16), .SONG_LEN(64), .ADDR_W(6), .SCORE(SCORE_A))
        u_c (.clk(clk), .rst_n(rst_n), .bus(bus_c.slave));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to cycle n of the current test; sampling/driving at #1 after the edge.
    task automatic go(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus_a.start = 0; bus_a.stop = 0; bus_a.loop_en = 0; bus_a.tempo_sel = 2'd0;
        bus_b.start = 0; bus_b.stop = 0; bus_b.loop_en = 0; bus_b.tempo_sel = 2'd0;
        bus_c.start = 0; bus_c.stop = 0; bus_c.loop_en = 0; bus_c.tempo_sel = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_max_preset", 32'(bus_a.max_preset), 0);
        chk("rst_tone_en",    32'(bus_a.tone_en),    0);
        chk("rst_note_code",  32'(bus_a.note_code),  0);
        chk("rst_note_addr",  32'(bus_a.note_addr),  0);
        chk("rst_busy",       32'(bus_a.busy),       0);
        chk("rst_song_done",  32'(bus_a.song_done),  0);
        rst_n = 1'b1;

        // Reset in the middle of a note
        cyc = 0;
        bus_a.start = 1; go(1); bus_a.start = 0;
        go(10);
        chk("pre_rst_preset", 32'(bus_a.max_preset), 1911);
        rst_n = 1'b0;
        #1;
        chk("async_rst_preset", 32'(bus_a.max_preset), 0);
        chk("async_rst_tone",   32'(bus_a.tone_en),    0);
        chk("async_rst_code",   32'(bus_a.note_code),  0);
        chk("async_rst_busy",   32'(bus_a.busy),       0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        chk("post_rst_busy", 32'(bus_a.busy), 0);

        // One pass of the score, no loop
        cyc = 0;
        bus_a.start = 1; go(1); bus_a.start = 0;
        chk("p_c1_busy",        32'(bus_a.busy),       1);
        go(2);
        chk("p_c2_tone",        32'(bus_a.tone_en),    0);
        go(3);
        chk("p_c3_preset",      32'(bus_a.max_preset), 1911);
        chk("p_c3_tone",        32'(bus_a.tone_en),    1);
        chk("p_c3_code",        32'(bus_a.note_code),  1);
        go(18);
        chk("p_c18_addr",       32'(bus_a.note_addr),  0);
        go(19);
        chk("p_c19_addr",       32'(bus_a.note_addr),  1);
        chk("p_c19_hold",       32'(bus_a.max_preset), 1911);
        go(20);
        chk("p_c20_hold_tone",  32'(bus_a.tone_en),    1);
        go(21);
        chk("p_c21_rest_tone",  32'(bus_a.tone_en),    0);
        chk("p_c21_rest_pre",   32'(bus_a.max_preset), 0);
        go(28);
        chk("p_c28_addr",       32'(bus_a.note_addr),  1);
        go(29);
        chk("p_c29_addr",       32'(bus_a.note_addr),  2);
        go(31);
        chk("p_c31_preset",     32'(bus_a.max_preset), 955);
        chk("p_c31_tone",       32'(bus_a.tone_en),    1);
        chk("p_c31_code",       32'(bus_a.note_code),  8);
        go(54);
        chk("p_c54_addr",       32'(bus_a.note_addr),  2);
        go(55);
        chk("p_c55_addr",       32'(bus_a.note_addr),  3);
        go(56);
        chk("p_c56_busy",       32'(bus_a.busy),       1);
        chk("p_c56_done",       32'(bus_a.song_done),  0);
        go(57);
        chk("p_c57_done",       32'(bus_a.song_done),  1);
        chk("p_c57_busy",       32'(bus_a.busy),       0);
        chk("p_c57_tone",       32'(bus_a.tone_en),    0);
        go(58);
        chk("p_c58_done",       32'(bus_a.song_done),  0);

        // Looped playback, then stop mid-note
        cyc = 0;
        bus_a.loop_en = 1;
        bus_a.start = 1; go(1); bus_a.start = 0;
        go(3);
        chk("l_c3_preset",  32'(bus_a.max_preset), 1911);
        go(55);
        chk("l_c55_addr",   32'(bus_a.note_addr),  3);
        go(57);
        chk("l_c57_addr",   32'(bus_a.note_addr),  0);
        chk("l_c57_busy",   32'(bus_a.busy),       1);
        chk("l_c57_done",   32'(bus_a.song_done),  0);
        chk("l_c57_hold",   32'(bus_a.max_preset), 955);
        go(58);
        chk("l_c58_done",   32'(bus_a.song_done),  0);
        go(59);
        chk("l_c59_preset", 32'(bus_a.max_preset), 1911);
        chk("l_c59_tone",   32'(bus_a.tone_en),    1);
        go(75);
        chk("l_c75_addr",   32'(bus_a.note_addr),  1);
        go(87);
        chk("l_c87_preset", 32'(bus_a.max_preset), 955);
        go(90);
        bus_a.stop = 1; go(91); bus_a.stop = 0;
        chk("stop_busy",    32'(bus_a.busy),       0);
        chk("stop_tone",    32'(bus_a.tone_en),    0);
        chk("stop_preset",  32'(bus_a.max_preset), 0);
        chk("stop_code",    32'(bus_a.note_code),  0);
        chk("stop_addr",    32'(bus_a.note_addr),  2);
        chk("stop_done",    32'(bus_a.song_done),  0);
        go(93);
        chk("stop_busy2",   32'(bus_a.busy),       0);
        bus_a.start = 1; bus_a.stop = 1; go(94); bus_a.start = 0; bus_a.stop = 0;
        chk("ss_busy",      32'(bus_a.busy),       0);
        chk("ss_tone",      32'(bus_a.tone_en),    0);
        chk("ss_preset",    32'(bus_a.max_preset), 0);
        chk("ss_addr",      32'(bus_a.note_addr),  2);
        go(96);
        chk("ss_busy2",     32'(bus_a.busy),       0);
        bus_a.loop_en = 0;

        // Empty song with loop enabled
        cyc = 0;
        bus_b.loop_en = 1;
        bus_b.start = 1; go(1); bus_b.start = 0;
        go(2);
        chk("e_c2_busy",  32'(bus_b.busy),      1);
        go(3);
        chk("e_c3_done",  32'(bus_b.song_done), 1);
        chk("e_c3_busy",  32'(bus_b.busy),      0);
        go(4);
        chk("e_c4_done",  32'(bus_b.song_done), 0);
        chk("e_c4_busy",  32'(bus_b.busy),      0);
        bus_b.start = 1; go(5); bus_b.start = 0;
        chk("e_c5_busy",  32'(bus_b.busy),      1);
        go(7);
        chk("e_c7_done",  32'(bus_b.song_done), 1);

        // Tempo change with the counter above the new terminal count
        cyc = 0;
        bus_c.start = 1; go(1); bus_c.start = 0;
        go(3);
        chk("t_c3_preset", 32'(bus_c.max_preset), 1911);
        go(5);
        bus_c.start = 1; go(6); bus_c.start = 0;
        go(8);
        bus_c.tempo_sel = 2'd2;
        go(12);
        chk("t_c12_addr",  32'(bus_c.note_addr),  0);
        go(13);
        chk("t_c13_addr",  32'(bus_c.note_addr),  1);
        chk("t_c13_busy",  32'(bus_c.busy),       1);
        go(15);
        chk("t_c15_tone",  32'(bus_c.tone_en),    0);
        go(18);
        chk("t_c18_addr",  32'(bus_c.note_addr),  1);
        go(19);
        chk("t_c19_addr",  32'(bus_c.note_addr),  2);
        bus_c.stop = 1; go(20); bus_c.stop = 0;
        chk("t_stop_busy", 32'(bus_c.busy),       0);
        bus_c.tempo_sel = 2'd0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
